// File: rtl/perf_counter_bank.sv
// perf_counter_bank: N-channel event counter bank with sticky overflow flags,
// atomic snapshot into shadow registers, soft clear and a registered read port.
// Optional threshold interrupt is built when PERF_CNT_THRESH_EN is defined.
// The per-channel strobe port is named evt ("event" is a reserved word).
module perf_counter_bank #(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 32,
  parameter int SEL_W    = 2,
  parameter int SAT_MODE = 0
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] evt,
  input  logic              sw_clear,
  input  logic              snap,
  input  logic [SEL_W-1:0]  rd_sel,
`ifdef PERF_CNT_THRESH_EN
  input  logic [WIDTH-1:0]  thresh_val,
  input  logic [SEL_W-1:0]  thresh_ch,
  input  logic              irq_ack,
  output logic              irq,
`endif
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_ovf,
  output logic [NUM_CH-1:0] ovf_flags,
  output logic              snap_valid
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0]  cnt     [NUM_CH];
  logic [WIDTH-1:0]  cnt_nxt [NUM_CH];
  logic [WIDTH-1:0]  shadow  [NUM_CH];
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] at_max;
  logic [WIDTH-1:0]  sel_data_p0;
  logic              sel_ovf_p0;

  // Per-channel increment request and next value (wrap or saturate at max)
  always_comb begin
    inc    = '0;
    at_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      inc[i]    = enable & evt[i];
      at_max[i] = (cnt[i] == CNT_MAX);
      if (at_max[i])
        cnt_nxt[i] = (SAT_MODE != 0) ? cnt[i] : '0;
      else
        cnt_nxt[i] = cnt[i] + WIDTH'(1);
    end
  end

  // Live counters, sticky flags, shadows and snapshot flag; clear beats count
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
      ovf_flags  <= '0;
      snap_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (snap)
          shadow[i] <= cnt[i];
        if (sw_clear)
          cnt[i] <= '0;
        else if (inc[i])
          cnt[i] <= cnt_nxt[i];
      end
      if (sw_clear)
        ovf_flags <= '0;
      else
        ovf_flags <= ovf_flags | (inc & at_max);
      if (snap)
        snap_valid <= 1'b1;
      else if (sw_clear)
        snap_valid <= 1'b0;
    end
  end

  // Read select mux; out-of-range selects fall through to zero
  always_comb begin
    sel_data_p0 = '0;
    sel_ovf_p0  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_data_p0 = shadow[i];
        sel_ovf_p0  = ovf_flags[i];
      end
    end
  end

  // ---- read stage p0 -> p1 ----
  // Registered read port feeding the display path
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      rd_data <= sel_data_p0;
      rd_ovf  <= sel_ovf_p0;
    end
  end

`ifdef PERF_CNT_THRESH_EN
  logic thresh_hit;

  // Selected channel actually steps onto the threshold (saturation hold excluded)
  always_comb begin
    thresh_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((thresh_ch == SEL_W'(i)) && inc[i] && !sw_clear &&
          !(at_max[i] && (SAT_MODE != 0)) && (cnt_nxt[i] == thresh_val))
        thresh_hit = 1'b1;
    end
  end

  // Sticky interrupt; a new hit wins over acknowledge
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)
      irq <= 1'b0;
    else if (thresh_hit)
      irq <= 1'b1;
    else if (irq_ack || sw_clear)
      irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: one 8-bit wrapping 4-channel instance
// and one 8-bit saturating 3-channel instance driven by the same stimulus.
module tb_perf_counter_bank;

  logic       clk = 1'b0;
  logic       clr_n, enable, sw_clear, snap;
  logic [3:0] evt;
  logic [1:0] rd_sel;

  logic [7:0] w_rd_data, s_rd_data;
  logic       w_rd_ovf, s_rd_ovf;
  logic [3:0] w_ovf;
  logic [2:0] s_ovf;
  logic       w_sv, s_sv;

`ifdef PERF_CNT_THRESH_EN
  logic [7:0] thresh_val;
  logic [1:0] thresh_ch;
  logic       irq_ack;
  logic       w_irq, s_irq;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(4), .WIDTH(8), .SEL_W(2), .SAT_MODE(0)) u_wrap (
    .clk(clk), .clr_n(clr_n), .enable(enable), .evt(evt),
    .sw_clear(sw_clear), .snap(snap), .rd_sel(rd_sel),
`ifdef PERF_CNT_THRESH_EN
    .thresh_val(thresh_val), .thresh_ch(thresh_ch), .irq_ack(irq_ack), .irq(w_irq),
`endif
    .rd_data(w_rd_data), .rd_ovf(w_rd_ovf), .ovf_flags(w_ovf), .snap_valid(w_sv)
  );

  perf_counter_bank #(.NUM_CH(3), .WIDTH(8), .SEL_W(2), .SAT_MODE(1)) u_sat (
    .clk(clk), .clr_n(clr_n), .enable(enable), .evt(evt[2:0]),
    .sw_clear(sw_clear), .snap(snap), .rd_sel(rd_sel),
`ifdef PERF_CNT_THRESH_EN
    .thresh_val(thresh_val), .thresh_ch(thresh_ch), .irq_ack(irq_ack), .irq(s_irq),
`endif
    .rd_data(s_rd_data), .rd_ovf(s_rd_ovf), .ovf_flags(s_ovf), .snap_valid(s_sv)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b0; enable = 1'b0; evt = 4'b0000;
    sw_clear = 1'b0; snap = 1'b0; rd_sel = 2'd0;
`ifdef PERF_CNT_THRESH_EN
    thresh_val = 8'd7; thresh_ch = 2'd3; irq_ack = 1'b0;
`endif
    step(2);
    chk_eq("rst_w_rd", 32'(w_rd_data), 0);
    chk_eq("rst_w_sv", 32'(w_sv), 0);
    chk_eq("rst_w_ovf", 32'(w_ovf), 0);
    chk_eq("rst_s_rd", 32'(s_rd_data), 0);
    clr_n = 1'b1;

    // basic count on ch0
    enable = 1'b1; evt = 4'b0001;
    step(10);
    evt = 4'b0000; snap = 1'b1;
    step(1);
    snap = 1'b0;
    step(1);
    chk_eq("cnt10_w_rd", 32'(w_rd_data), 10);
    chk_eq("cnt10_s_rd", 32'(s_rd_data), 10);
    chk_eq("cnt10_w_sv", 32'(w_sv), 1);
    chk_eq("cnt10_w_rdovf", 32'(w_rd_ovf), 0);
    for (int ch = 1; ch < 4; ch++) begin
      rd_sel = 2'(ch);
      step(1);
      chk_eq("idle_ch_w", 32'(w_rd_data), 0);
      chk_eq("idle_ch_s", 32'(s_rd_data), 0);
    end

    // ch3 exists only on the wrap instance; out of range on the 3-channel one
    evt = 4'b1000;
    step(3);
    evt = 4'b0000; snap = 1'b1;
    step(1);
    snap = 1'b0; rd_sel = 2'd3;
    step(1);
    chk_eq("ch3_w_rd", 32'(w_rd_data), 3);
    chk_eq("oor_s_rd", 32'(s_rd_data), 0);
    chk_eq("oor_s_rdovf", 32'(s_rd_ovf), 0);

    // clear keeps shadows; wrap vs saturate on ch1 with 257 events
    sw_clear = 1'b1;
    step(1);
    sw_clear = 1'b0;
    chk_eq("clr_w_sv", 32'(w_sv), 0);
    rd_sel = 2'd0;
    step(1);
    chk_eq("clr_keep_shadow", 32'(w_rd_data), 10);
    evt = 4'b0010;
    step(257);
    evt = 4'b0000;
    chk_eq("wrap_w_ovf", 32'(w_ovf), 2);
    chk_eq("wrap_s_ovf", 32'(s_ovf), 2);
    snap = 1'b1; rd_sel = 2'd1;
    step(1);
    snap = 1'b0;
    step(1);
    chk_eq("wrap_w_rd", 32'(w_rd_data), 1);
    chk_eq("wrap_w_rdovf", 32'(w_rd_ovf), 1);
    chk_eq("wrap_s_rd", 32'(s_rd_data), 255);
    chk_eq("wrap_s_rdovf", 32'(s_rd_ovf), 1);

    // saturate on ch2 with 300 events
    sw_clear = 1'b1;
    step(1);
    sw_clear = 1'b0; evt = 4'b0100;
    step(300);
    evt = 4'b0000;
    chk_eq("sat_s_ovf", 32'(s_ovf), 4);
    chk_eq("sat_w_ovf", 32'(w_ovf), 4);
    snap = 1'b1; rd_sel = 2'd2;
    step(1);
    snap = 1'b0;
    step(1);
    chk_eq("sat_s_rd", 32'(s_rd_data), 255);
    chk_eq("sat_s_rdovf", 32'(s_rd_ovf), 1);
    chk_eq("sat_w_rd", 32'(w_rd_data), 44);
    sw_clear = 1'b1;
    step(1);
    sw_clear = 1'b0;
    chk_eq("satclr_s_ovf", 32'(s_ovf), 0);
    chk_eq("satclr_w_ovf", 32'(w_ovf), 0);
    snap = 1'b1;
    step(1);
    snap = 1'b0;
    step(1);
    chk_eq("satclr_s_rd", 32'(s_rd_data), 0);
    chk_eq("satclr_w_rd", 32'(w_rd_data), 0);
    chk_eq("satclr_s_rdovf", 32'(s_rd_ovf), 0);

    // snap + clear + increment in one cycle
    evt = 4'b0001;
    step(5);
    snap = 1'b1; sw_clear = 1'b1; rd_sel = 2'd0;
    step(1);
    snap = 1'b0; sw_clear = 1'b0; evt = 4'b0000;
    chk_eq("simul_w_sv", 32'(w_sv), 1);
    chk_eq("simul_s_sv", 32'(s_sv), 1);
    step(1);
    chk_eq("simul_w_rd", 32'(w_rd_data), 5);
    chk_eq("simul_s_rd", 32'(s_rd_data), 5);
    snap = 1'b1;
    step(1);
    snap = 1'b0;
    step(1);
    chk_eq("simul_live0", 32'(w_rd_data), 0);

    // freeze with enable low
    evt = 4'b1111;
    step(3);
    enable = 1'b0;
    step(20);
    snap = 1'b1; rd_sel = 2'd1;
    step(1);
    snap = 1'b0;
    step(1);
    chk_eq("frz_w_rd", 32'(w_rd_data), 3);
    chk_eq("frz_s_rd", 32'(s_rd_data), 3);

    // asynchronous reset in the middle of the high phase
    @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk_eq("arst_w_rd", 32'(w_rd_data), 0);
    chk_eq("arst_s_rd", 32'(s_rd_data), 0);
    chk_eq("arst_w_sv", 32'(w_sv), 0);
    chk_eq("arst_s_sv", 32'(s_sv), 0);
    @(negedge clk);
    clr_n = 1'b1; evt = 4'b0000; enable = 1'b1;

`ifdef PERF_CNT_THRESH_EN
    // threshold interrupt on ch3 at value 7
    step(1);
    chk_eq("irq_idle", 32'(w_irq), 0);
    evt = 4'b1000;
    step(6);
    chk_eq("irq_pre", 32'(w_irq), 0);
    step(1);
    evt = 4'b0000;
    chk_eq("irq_hit_w", 32'(w_irq), 1);
    chk_eq("irq_oor_s", 32'(s_irq), 0);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    chk_eq("irq_ack", 32'(w_irq), 0);
    evt = 4'b1000;
    step(1);
    evt = 4'b0000;
    chk_eq("irq_past", 32'(w_irq), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
